// File: rtl/cbus_burst_responder.sv
// cbus_burst_responder: memory-side CBus endpoint serving wrap-around
// (critical-word-first) cache-line bursts from a local word memory, with a
// programmable first-beat latency.
// Build option: define CBUS_RESPONDER_STALL_EN to insert LFSR-driven beat
// stalls for verification; undefined gives strictly back-to-back beats.

package cbus_pkg;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [3:0]  order;
    logic [31:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic        okay;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;
endpackage

module cbus_burst_responder
  import cbus_pkg::*;
#(
  parameter int    MEM_ADDR_BITS = 12,
  parameter int    LATENCY       = 2,
  parameter string INIT_FILE     = ""
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  cbus_req,
  output cbus_resp_t cbus_resp
);

  localparam int         AW       = MEM_ADDR_BITS;
  localparam int         DEPTH    = 1 << AW;
  localparam logic [3:0] ORD_MAX  = 4'(AW);
  localparam logic [3:0] LAT_INIT = 4'(LATENCY - 1);
  localparam bit         LAT_ONE  = (LATENCY == 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t          state;
  logic [3:0]      lat_cnt;
  logic [AW-1:0]   beat;      // beat on the bus when okay_q, else next to present
  logic            okay_q;
  logic            last_q;
  logic [31:0]     rdata_q;
  logic            is_wr;
  logic [AW-1:0]   base;
  logic [3:0]      ord;
  logic            stall;

  logic [31:0]     mem [DEPTH];

  logic [AW-1:0]   req_word;
  logic [3:0]      req_ord;
  logic [AW-1:0]   nxt_beat;
  logic            wr_en;
  logic [AW-1:0]   wr_word;

  // Low 'o' bits of the word address wrap; upper bits stay fixed.
  function automatic logic [AW-1:0] beat_mask(input logic [3:0] o);
    return ~({AW{1'b1}} << o);
  endfunction

  function automatic logic [AW-1:0] wrap_word(input logic [AW-1:0] b,
                                              input logic [3:0]    o,
                                              input logic [AW-1:0] n);
    logic [AW-1:0] m;
    m = beat_mask(o);
    return (b & ~m) | ((b + n) & m);
  endfunction

`ifdef CBUS_RESPONDER_STALL_EN
  logic [15:0] lfsr;

  // Fibonacci LFSR, taps 16/14/13/11, free-running stall source
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = lfsr[0];
`else
  assign stall = 1'b0;
`endif

  assign req_word = cbus_req.addr[AW+1:2];
  assign req_ord  = (cbus_req.order > ORD_MAX) ? ORD_MAX : cbus_req.order;
  assign nxt_beat = okay_q ? beat + 1'b1 : beat;
  assign wr_en    = (state == BURST) && okay_q && cbus_req.valid && is_wr;
  assign wr_word  = wrap_word(base, ord, beat);

  // Burst sequencer: accept, count down latency, then present wrapped beats
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      lat_cnt <= '0;
      beat    <= '0;
      okay_q  <= 1'b0;
      last_q  <= 1'b0;
      rdata_q <= '0;
      is_wr   <= 1'b0;
      base    <= '0;
      ord     <= '0;
    end else begin
      case (state)
        IDLE: begin
          okay_q <= 1'b0;
          last_q <= 1'b0;
          if (cbus_req.valid) begin
            is_wr <= cbus_req.is_write;
            base  <= req_word;
            ord   <= req_ord;
            beat  <= '0;
            if (LAT_ONE) begin
              state <= BURST;
              if (!stall) begin
                okay_q  <= 1'b1;
                last_q  <= (req_ord == 4'd0);
                rdata_q <= mem[req_word];
              end
            end else begin
              state   <= WAIT;
              lat_cnt <= LAT_INIT;
            end
          end
        end
        WAIT: begin
          if (!cbus_req.valid) begin
            state   <= IDLE;
            lat_cnt <= '0;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
            if (lat_cnt == 4'd1) begin
              state <= BURST;
              beat  <= '0;
              if (!stall) begin
                okay_q  <= 1'b1;
                last_q  <= (ord == 4'd0);
                rdata_q <= mem[base];
              end
            end
          end
        end
        BURST: begin
          if (!cbus_req.valid || (okay_q && last_q)) begin
            state  <= IDLE;
            okay_q <= 1'b0;
            last_q <= 1'b0;
            beat   <= '0;
          end else begin
            beat <= nxt_beat;
            if (stall) begin
              okay_q <= 1'b0;
              last_q <= 1'b0;
            end else begin
              okay_q  <= 1'b1;
              last_q  <= (nxt_beat == beat_mask(ord));
              rdata_q <= mem[wrap_word(base, ord, nxt_beat)];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write beats commit on the edge closing a valid okay cycle
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_word] <= cbus_req.wdata;
  end

  assign cbus_resp.okay  = okay_q & cbus_req.valid;
  assign cbus_resp.last  = last_q;
  assign cbus_resp.rdata = rdata_q;

endmodule

// File: tb/tb_cbus_burst_responder.sv
// Self-checking bench for cbus_burst_responder with a word-array memory model.
module tb_cbus_burst_responder;
  import cbus_pkg::*;

  localparam int AW    = 12;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << AW;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  req;
  cbus_resp_t resp;

  always #5 clk = ~clk;

  cbus_burst_responder #(.MEM_ADDR_BITS(AW), .LATENCY(LAT), .INIT_FILE("")) dut (
    .clk(clk),
    .reset(reset),
    .cbus_req(req),
    .cbus_resp(resp)
  );

  int tests = 0;
  int fails = 0;
  bit exact_timing;

  logic [31:0] model_mem [DEPTH];
  int          obs_cyc[$];
  logic [31:0] obs_rdata[$];
  logic        obs_last[$];

  function automatic int eff_ord(input int o);
    return (o > AW) ? AW : o;
  endfunction

  // Word touched by beat b: aligned block of 2**order words, start offset rotates.
  function automatic int beat_word(input logic [31:0] addr, input int o, input int b);
    int w, n, base;
    w    = int'((addr >> 2) % DEPTH);
    n    = 1 << eff_ord(o);
    base = w - (w % n);
    return base + ((w % n) + b) % n;
  endfunction

  // Drives one burst from the current cycle T, records every okay cycle.
  task automatic burst(input bit wr, input logic [31:0] addr, input int o,
                       input logic [31:0] wbase, input bit keep, input int stop_after);
    int n, beats, budget;
    n      = 1 << eff_ord(o);
    beats  = 0;
    budget = 4 * n + 40;
    obs_cyc.delete();
    obs_rdata.delete();
    obs_last.delete();
    req.valid    = 1'b1;
    req.is_write = wr;
    req.addr     = addr;
    req.order    = o[3:0];
    req.wdata    = wbase;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      req.wdata = wbase + 32'(beats);
      @(negedge clk);
      if (resp.okay) begin
        obs_cyc.push_back(c);
        obs_rdata.push_back(resp.rdata);
        obs_last.push_back(resp.last);
        if (wr) model_mem[beat_word(addr, o, beats)] = wbase + 32'(beats);
        beats++;
        if (resp.last || beats == n || beats == stop_after) break;
      end
    end
    @(posedge clk); #1;
    if (!keep) req.valid = 1'b0;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    req.valid    = 1'b1;
    req.is_write = 1'b0;
    req.addr     = '0;
    req.order    = '0;
    req.wdata    = '0;
    #3;
    tests++; if (resp.okay !== 1'b0) begin fails++; $display("FAIL reset_okay got %b want 0", resp.okay); end
    tests++; if (resp.last !== 1'b0) begin fails++; $display("FAIL reset_last got %b want 0", resp.last); end
    tests++; if (resp.rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", resp.rdata); end
    req.valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    burst(1'b1, 32'h0, AW, 32'h1000, 1'b0, 0);
    tests++; if (obs_cyc.size() !== DEPTH) begin fails++; $display("FAIL fill_beats got %0d want %0d", obs_cyc.size(), DEPTH); end
    if (obs_cyc.size() == DEPTH) begin
      tests++; if (obs_last[DEPTH-1] !== 1'b1 || obs_last[DEPTH-2] !== 1'b0) begin
        fails++; $display("FAIL fill_last got %b%b want 01", obs_last[DEPTH-2], obs_last[DEPTH-1]); end
    end
  endtask

  task automatic test_wrap_read();
    logic [31:0] exp_data [4];
    exp_data = '{32'h1002, 32'h1003, 32'h1000, 32'h1001};
    burst(1'b0, 32'h08, 2, 32'h0, 1'b0, 0);
    tests++; if (obs_cyc.size() !== 4) begin fails++; $display("FAIL wrap_read_beats got %0d want 4", obs_cyc.size()); end
    for (int k = 0; k < obs_cyc.size() && k < 4; k++) begin
      tests++; if (obs_rdata[k] !== exp_data[k]) begin fails++; $display("FAIL wrap_read_data beat %0d got %h want %h", k, obs_rdata[k], exp_data[k]); end
      tests++; if (obs_last[k] !== (k == 3)) begin fails++; $display("FAIL wrap_read_last beat %0d got %b want %b", k, obs_last[k], k == 3); end
      tests++; if (exact_timing ? (obs_cyc[k] != LAT + k) : (obs_cyc[k] < LAT + k)) begin
        fails++; $display("FAIL wrap_read_cycle beat %0d got %0d want %0d", k, obs_cyc[k], LAT + k); end
    end
  endtask

  task automatic test_wrap_write();
    logic [31:0] exp_data [4];
    exp_data = '{32'hA3, 32'hA0, 32'hA1, 32'hA2};
    burst(1'b1, 32'h34, 2, 32'hA0, 1'b0, 0);
    tests++; if (obs_cyc.size() !== 4) begin fails++; $display("FAIL wrap_write_beats got %0d want 4", obs_cyc.size()); end
    burst(1'b0, 32'h30, 2, 32'h0, 1'b0, 0);
    tests++; if (obs_cyc.size() !== 4) begin fails++; $display("FAIL wrap_rb_beats got %0d want 4", obs_cyc.size()); end
    for (int k = 0; k < obs_cyc.size() && k < 4; k++) begin
      tests++; if (obs_rdata[k] !== exp_data[k]) begin fails++; $display("FAIL wrap_rb_data beat %0d got %h want %h", k, obs_rdata[k], exp_data[k]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ra, wa, wb;
    ra = $urandom; wa = $urandom; wb = $urandom;
    burst(1'b0, ra, 2, 32'h0, 1'b1, 0);
    tests++; if (obs_cyc.size() !== 4) begin fails++; $display("FAIL b2b_read_beats got %0d want 4", obs_cyc.size()); end
    for (int k = 0; k < obs_cyc.size() && k < 4; k++) begin
      tests++; if (obs_rdata[k] !== model_mem[beat_word(ra, 2, k)]) begin
        fails++; $display("FAIL b2b_read_data beat %0d got %h want %h", k, obs_rdata[k], model_mem[beat_word(ra, 2, k)]); end
    end
    burst(1'b1, wa, 2, wb, 1'b0, 0);
    tests++; if (obs_cyc.size() !== 4) begin fails++; $display("FAIL b2b_write_beats got %0d want 4", obs_cyc.size()); end
    if (obs_cyc.size() > 0) begin
      tests++; if (exact_timing ? (obs_cyc[0] != LAT) : (obs_cyc[0] < LAT)) begin
        fails++; $display("FAIL b2b_write_first got %0d want %0d", obs_cyc[0], LAT); end
    end
    burst(1'b0, wa, 2, 32'h0, 1'b0, 0);
    for (int k = 0; k < obs_cyc.size() && k < 4; k++) begin
      tests++; if (obs_rdata[k] !== model_mem[beat_word(wa, 2, k)]) begin
        fails++; $display("FAIL b2b_rb_data beat %0d got %h want %h", k, obs_rdata[k], model_mem[beat_word(wa, 2, k)]); end
    end
  endtask

  task automatic test_single();
    burst(1'b0, 32'h7FFC, 0, 32'h0, 1'b0, 0);
    tests++; if (obs_cyc.size() !== 1) begin fails++; $display("FAIL single_beats got %0d want 1", obs_cyc.size()); end
    if (obs_cyc.size() > 0) begin
      tests++; if (obs_last[0] !== 1'b1) begin fails++; $display("FAIL single_last got %b want 1", obs_last[0]); end
      tests++; if (obs_rdata[0] !== model_mem[12'hFFF]) begin fails++; $display("FAIL single_data got %h want %h", obs_rdata[0], model_mem[12'hFFF]); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] a, wb;
    a = $urandom; wb = $urandom;
    burst(1'b1, a, 3, wb, 1'b0, 2);
    tests++; if (obs_cyc.size() !== 2) begin fails++; $display("FAIL abort_beats got %0d want 2", obs_cyc.size()); end
    @(negedge clk);
    tests++; if (resp.okay !== 1'b0) begin fails++; $display("FAIL abort_okay got %b want 0", resp.okay); end
    @(posedge clk); #1;
    burst(1'b0, a, 3, 32'h0, 1'b0, 0);
    tests++; if (obs_cyc.size() !== 8) begin fails++; $display("FAIL abort_rb_beats got %0d want 8", obs_cyc.size()); end
    if (obs_cyc.size() > 0) begin
      tests++; if (exact_timing ? (obs_cyc[0] != LAT) : (obs_cyc[0] < LAT)) begin
        fails++; $display("FAIL abort_idle_first got %0d want %0d", obs_cyc[0], LAT); end
    end
    for (int k = 0; k < obs_cyc.size() && k < 8; k++) begin
      tests++; if (obs_rdata[k] !== model_mem[beat_word(a, 3, k)]) begin
        fails++; $display("FAIL abort_rb_data beat %0d got %h want %h", k, obs_rdata[k], model_mem[beat_word(a, 3, k)]); end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    logic [31:0] a;
    seen = 1'b0;
    req.valid = 1'b1; req.is_write = 1'b0; req.addr = $urandom; req.order = 4'd0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (resp.okay) seen = 1'b1;
    end
    tests++; if (seen !== 1'b1 || resp.last !== 1'b1) begin fails++; $display("FAIL rstmid_pre got okay %b last %b want 1 1", seen, resp.last); end
    #2 reset = 1'b1;
    #1;
    tests++; if (resp.okay !== 1'b0) begin fails++; $display("FAIL rstmid_okay got %b want 0", resp.okay); end
    tests++; if (resp.last !== 1'b0) begin fails++; $display("FAIL rstmid_last got %b want 0", resp.last); end
    req.valid = 1'b0;
    #1 reset = 1'b0;
    @(posedge clk); #1;
    a = $urandom;
    burst(1'b0, a, 2, 32'h0, 1'b0, 0);
    tests++; if (obs_cyc.size() !== 4) begin fails++; $display("FAIL rstmid_next_beats got %0d want 4", obs_cyc.size()); end
    for (int k = 0; k < obs_cyc.size() && k < 4; k++) begin
      tests++; if (obs_rdata[k] !== model_mem[beat_word(a, 2, k)]) begin
        fails++; $display("FAIL rstmid_next_data beat %0d got %h want %h", k, obs_rdata[k], model_mem[beat_word(a, 2, k)]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      bit wr; int o, n; logic [31:0] a, wb;
      wr = 1'($urandom_range(0, 1));
      o  = $urandom_range(0, 5);
      a  = $urandom; wb = $urandom;
      n  = 1 << o;
      burst(wr, a, o, wb, 1'($urandom_range(0, 1)), 0);
      tests++; if (obs_cyc.size() !== n) begin fails++; $display("FAIL rand_beats it %0d got %0d want %0d", it, obs_cyc.size(), n); end
      for (int k = 0; k < obs_cyc.size() && k < n; k++) begin
        if (!wr) begin
          tests++; if (obs_rdata[k] !== model_mem[beat_word(a, o, k)]) begin
            fails++; $display("FAIL rand_data it %0d beat %0d got %h want %h", it, k, obs_rdata[k], model_mem[beat_word(a, o, k)]); end
        end
        tests++; if (obs_last[k] !== (k == n - 1)) begin
          fails++; $display("FAIL rand_last it %0d beat %0d got %b want %b", it, k, obs_last[k], k == n - 1); end
      end
    end
    req.valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clamp();
    logic [31:0] a;
    int bad;
    a = $urandom; bad = 0;
    burst(1'b0, a, 14, 32'h0, 1'b0, 0);
    tests++; if (obs_cyc.size() !== DEPTH) begin fails++; $display("FAIL clamp_beats got %0d want %0d", obs_cyc.size(), DEPTH); end
    for (int k = 0; k < obs_cyc.size() && k < DEPTH; k++)
      if (obs_rdata[k] !== model_mem[beat_word(a, 14, k)]) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL clamp_data got %0d wrong beats want 0", bad); end
  endtask

`ifdef CBUS_RESPONDER_STALL_EN
  task automatic test_stall();
    logic [31:0] a;
    a = $urandom;
    burst(1'b0, a, 4, 32'h0, 1'b0, 0);
    tests++; if (obs_cyc.size() !== 16) begin fails++; $display("FAIL stall_beats got %0d want 16", obs_cyc.size()); end
    for (int k = 0; k < obs_cyc.size() && k < 16; k++) begin
      tests++; if (obs_rdata[k] !== model_mem[beat_word(a, 4, k)]) begin
        fails++; $display("FAIL stall_data beat %0d got %h want %h", k, obs_rdata[k], model_mem[beat_word(a, 4, k)]); end
    end
    if (obs_cyc.size() == 16) begin
      tests++; if (obs_cyc[15] <= 15 + LAT) begin fails++; $display("FAIL stall_duration got %0d want > %0d", obs_cyc[15], 15 + LAT); end
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef CBUS_RESPONDER_STALL_EN
    exact_timing = 1'b0;
`else
    exact_timing = 1'b1;
`endif
    test_reset();
    test_fill();
    test_wrap_read();
    test_wrap_write();
    test_back_to_back();
    test_single();
    test_abort();
    test_reset_mid();
    test_random();
    test_clamp();
`ifdef CBUS_RESPONDER_STALL_EN
    test_stall();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
